obi_data_arbiter: RTL and testbench
===================================

OBI_DATA_ARBITER -- requirements
Module: obi_data_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of OBI data masters (legal 2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-004 Parameter MAX_OUTSTANDING, default 2, depth of response-routing FIFO (legal 1..8).
REQ-005 Parameter ARB_MODE, default 1, 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-006 Clock and reset: one clock, clk_i; reset rst_i, synchronous, active-high.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 m_req_i  in  NUM_MASTERS  per-master request.
REQ-010 m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address.
REQ-011 m_we_i  in  NUM_MASTERS  per-master write enable.
REQ-012 m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte enables.
REQ-013 m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
REQ-014 m_gnt_o  out  NUM_MASTERS  per-master grant.
REQ-015 m_rvalid_o  out  NUM_MASTERS  per-master response valid.
REQ-016 m_rdata_o  out  NUM_MASTERS*DATA_WIDTH  per-master read data.
REQ-017 s_req_o / s_addr_o / s_we_o / s_be_o / s_wdata_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  slave request channel.
REQ-018 s_gnt_i / s_rvalid_i  in  1/1  slave grant, response valid; s_rdata_i  in  DATA_WIDTH  slave read data.
REQ-019 outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  accepted-but-unanswered transfer count.
REQ-020 resp_err_o  out  1  sticky flag: s_rvalid_i seen with no outstanding transfer.

Function
REQ-021 Winner selection combinational from m_req_i; fixed mode: lowest requesting index; RR mode: first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
REQ-022 s_req_o = any m_req_i high AND outstanding_o < MAX_OUTSTANDING; same-cycle pop does not lift the full stall.
REQ-023 s_addr_o, s_we_o, s_be_o, s_wdata_o carry the winner's fields; all zero when s_req_o low.
REQ-024 Transfer accepted when s_req_o && s_gnt_i; m_gnt_o[winner] = s_gnt_i && s_req_o, all other m_gnt_o low, zero-cycle latency.
REQ-025 Address-phase stability: if s_req_o high and s_gnt_i low, winner registered as locked; locked master stays winner until granted, regardless of new higher-priority requests.
REQ-026 Lock clears on the accepting cycle; a master dropping m_req_i while locked (protocol violation) also clears the lock.
REQ-027 RR mode: on acceptance rr_ptr <= (winner+1) mod NUM_MASTERS; unchanged otherwise; unused in fixed mode.
REQ-028 On acceptance, winner index pushed to routing FIFO; on s_rvalid_i with FIFO non-empty, head popped.
REQ-029 m_rvalid_o[head] = s_rvalid_i while FIFO non-empty, others low; zero-cycle latency.
REQ-030 m_rdata_o: every lane carries s_rdata_i.
REQ-031 Simultaneous push and pop: both occur, count unchanged, response routed to the pre-push head.
REQ-032 s_rvalid_i with FIFO empty: no m_rvalid_o asserted, count stays 0, resp_err_o set until reset.
REQ-033 outstanding_o = FIFO occupancy, registered; pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-034 While rst_i high at a clk_i edge: FIFO emptied, outstanding_o=0, rr_ptr=0, lock cleared, resp_err_o=0.
REQ-035 Combinational outputs follow REQ-022..REQ-029 from reset state, so with no requests all outputs are 0.
REQ-036 Reset mid-operation discards outstanding routing entries; later s_rvalid_i sets resp_err_o.

Verification
REQ-037 N=2, RR, both m_req_i high, s_gnt_i=1 for 4 cycles, s_rvalid_i 1 cycle later -> grants alternate 0,1,0,1; rvalid alternates 0,1,0,1.
REQ-038 Fixed mode, m_req_i=4'b1110, s_gnt_i=1 -> m_gnt_o=4'b0010 every cycle; master 3 starved.
REQ-039 Master 1 requests, s_gnt_i=0 for 3 cycles, master 0 requests from cycle 2 -> winner stays 1, gnt to 1 on cycle 4, master 0 next.
REQ-040 MAX_OUTSTANDING=2, s_gnt_i=1, s_rvalid_i=0 -> 2 accepted, s_req_o low, outstanding_o=2; one s_rvalid_i pulse -> s_req_o high next cycle.
REQ-041 s_rvalid_i with outstanding_o=0 -> no m_rvalid_o, resp_err_o=1 until rst_i.
REQ-042 Two outstanding, rst_i pulsed -> outstanding_o=0, rr_ptr=0; next s_rvalid_i sets resp_err_o.

Source files
------------

// File: rtl/obi_data_arbiter.sv
// OBI data-channel arbiter: N masters share one slave port. Address-phase
// winner is chosen by fixed priority or round-robin and held stable while the
// slave stalls. A small FIFO of winner indices routes each in-order response
// back to the master that issued the transfer.
//
// Handshake: a transfer is accepted on a cycle where s_req_o && s_gnt_i; the
// winning master sees m_gnt_o in that same cycle. A response is delivered on a
// cycle where s_rvalid_i is high and at least one transfer is outstanding;
// there is no backpressure on the response channel.
module obi_data_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_MASTERS-1:0]              m_req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]              m_gnt_o,
  output logic [NUM_MASTERS-1:0]              m_rvalid_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
  output logic                                s_req_o,
  output logic [ADDR_WIDTH-1:0]               s_addr_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_be_o,
  output logic [DATA_WIDTH-1:0]               s_wdata_o,
  input  logic                                s_gnt_i,
  input  logic                                s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]               s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                resp_err_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = DATA_WIDTH / 8;

  // Architectural state
  logic [IW-1:0] rr_ptr_q;
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          resp_err_q;

  // Derived control
  logic          any_req;
  logic [IW-1:0] winner;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [IW-1:0] head;

  // First requester at or after ptr, wrapping around the master list.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Lowest requesting index wins.
  function automatic logic [IW-1:0] fixed_pick(input logic [NUM_MASTERS-1:0] req);
    logic [IW-1:0] pick;
    pick = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) pick = IW'(i);
    end
    return pick;
  endfunction

  // Winner selection; a stalled (locked) master keeps the slot until granted.
  always_comb begin
    any_req = |m_req_i;
    if (lock_q && m_req_i[lock_idx_q]) begin
      winner = lock_idx_q;
    end else if (ARB_MODE == 1) begin
      winner = rr_pick(m_req_i, rr_ptr_q);
    end else begin
      winner = fixed_pick(m_req_i);
    end
  end

  // Request gating, acceptance and FIFO push/pop qualification.
  always_comb begin
    fifo_empty = (count_q == '0);
    s_req_o    = any_req && (count_q < CW'(MAX_OUTSTANDING));
    accept     = s_req_o && s_gnt_i;
    push       = accept;
    pop        = s_rvalid_i && !fifo_empty;
    head       = fifo_mem[rd_ptr_q];
  end

  // Slave request channel carries the winner's fields, zero when idle.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = m_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      s_we_o    = m_we_i[winner];
      s_be_o    = m_be_i[winner*BW +: BW];
      s_wdata_o = m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant to the winner and response routing to the FIFO head.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_gnt_o[winner] = accept;
    if (!fifo_empty) m_rvalid_o[head] = s_rvalid_i;
    m_rdata_o  = {NUM_MASTERS{s_rdata_i}};
  end

  // Lock and round-robin pointer: lock when presenting but not granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      if (s_req_o && !s_gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= winner;
      end else begin
        lock_q     <= 1'b0;
      end
      if (accept && (ARB_MODE == 1)) begin
        rr_ptr_q <= (winner == IW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  // Routing FIFO storage; entries need no reset since count gates reads.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= winner;
  end

  // FIFO pointers, occupancy and the sticky stray-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (s_rvalid_i && fifo_empty) resp_err_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Directed bench: a 2-master round-robin instance and a 4-master fixed-priority
// instance driven through a linear sequence of hand-computed steps.
module tb_obi_data_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Round-robin instance: 2 masters, 2 outstanding
  logic [1:0]  r_req = '0;
  logic [63:0] r_addr = {32'hB000_0004, 32'hA000_0000};
  logic [1:0]  r_we = 2'b10;
  logic [7:0]  r_be = {4'hC, 4'h3};
  logic [63:0] r_wdata = {32'h1111_1111, 32'h0000_0000};
  logic [1:0]  r_gnt;
  logic [1:0]  r_rvalid;
  logic [63:0] r_rdata;
  logic        r_s_req;
  logic [31:0] r_s_addr;
  logic        r_s_we;
  logic [3:0]  r_s_be;
  logic [31:0] r_s_wdata;
  logic        r_s_gnt = 1'b0;
  logic        r_s_rvalid = 1'b0;
  logic [31:0] r_s_rdata = '0;
  logic [1:0]  r_out;
  logic        r_err;

  // Fixed-priority instance: 4 masters, 2 outstanding
  logic [3:0]   f_req = '0;
  logic [127:0] f_addr = {32'h3000_0030, 32'h2000_0020, 32'h1000_0010, 32'h0000_0000};
  logic [3:0]   f_we = 4'b0010;
  logic [15:0]  f_be = {4'h8, 4'h4, 4'h2, 4'h1};
  logic [127:0] f_wdata = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  logic [3:0]   f_gnt;
  logic [3:0]   f_rvalid;
  logic [127:0] f_rdata;
  logic         f_s_req;
  logic [31:0]  f_s_addr;
  logic         f_s_we;
  logic [3:0]   f_s_be;
  logic [31:0]  f_s_wdata;
  logic         f_s_gnt = 1'b0;
  logic         f_s_rvalid = 1'b0;
  logic [31:0]  f_s_rdata = '0;
  logic [1:0]   f_out;
  logic         f_err;

  obi_data_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .ARB_MODE(1)
  ) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(r_req), .m_addr_i(r_addr), .m_we_i(r_we), .m_be_i(r_be), .m_wdata_i(r_wdata),
    .m_gnt_o(r_gnt), .m_rvalid_o(r_rvalid), .m_rdata_o(r_rdata),
    .s_req_o(r_s_req), .s_addr_o(r_s_addr), .s_we_o(r_s_we), .s_be_o(r_s_be), .s_wdata_o(r_s_wdata),
    .s_gnt_i(r_s_gnt), .s_rvalid_i(r_s_rvalid), .s_rdata_i(r_s_rdata),
    .outstanding_o(r_out), .resp_err_o(r_err)
  );

  obi_data_arbiter #(
    .NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .ARB_MODE(0)
  ) u_fx (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(f_req), .m_addr_i(f_addr), .m_we_i(f_we), .m_be_i(f_be), .m_wdata_i(f_wdata),
    .m_gnt_o(f_gnt), .m_rvalid_o(f_rvalid), .m_rdata_o(f_rdata),
    .s_req_o(f_s_req), .s_addr_o(f_s_addr), .s_we_o(f_s_we), .s_be_o(f_s_be), .s_wdata_o(f_s_wdata),
    .s_gnt_i(f_s_gnt), .s_rvalid_i(f_s_rvalid), .s_rdata_i(f_s_rdata),
    .outstanding_o(f_out), .resp_err_o(f_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    // Reset both instances
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rr_reset_out", r_out, 0);
    chk("rr_reset_err", r_err, 0);
    chk("rr_reset_sreq", r_s_req, 0);
    chk("rr_reset_gnt", r_gnt, 0);
    chk("rr_reset_rvalid", r_rvalid, 0);
    chk("rr_reset_saddr", r_s_addr, 0);
    chk("fx_reset_out", f_out, 0);
    chk("fx_reset_sreq", f_s_req, 0);

    // Round-robin alternation with responses one cycle behind
    r_req = 2'b11; r_s_gnt = 1'b1; #1;
    chk("rr_alt_gnt0", r_gnt, 2'b01);
    chk("rr_alt_addr0", r_s_addr, 32'hA000_0000);
    chk("rr_alt_rv0", r_rvalid, 2'b00);
    tick();
    r_s_rvalid = 1'b1; r_s_rdata = 32'hD0D0_0001; #1;
    chk("rr_alt_gnt1", r_gnt, 2'b10);
    chk("rr_alt_addr1", r_s_addr, 32'hB000_0004);
    chk("rr_alt_we1", r_s_we, 1);
    chk("rr_alt_be1", r_s_be, 4'hC);
    chk("rr_alt_wdata1", r_s_wdata, 32'h1111_1111);
    chk("rr_alt_rv1", r_rvalid, 2'b01);
    chk("rr_alt_rdata", r_rdata, {32'hD0D0_0001, 32'hD0D0_0001});
    tick();
    chk("rr_alt_out_steady", r_out, 1);
    chk("rr_alt_gnt2", r_gnt, 2'b01);
    chk("rr_alt_rv2", r_rvalid, 2'b10);
    tick();
    chk("rr_alt_gnt3", r_gnt, 2'b10);
    chk("rr_alt_rv3", r_rvalid, 2'b01);
    tick();
    r_req = 2'b00; r_s_gnt = 1'b0; #1;
    chk("rr_alt_gnt_idle", r_gnt, 2'b00);
    chk("rr_alt_rv4", r_rvalid, 2'b10);
    tick();
    r_s_rvalid = 1'b0; #1;
    chk("rr_alt_out_drained", r_out, 0);
    chk("rr_alt_err_clear", r_err, 0);

    // Outstanding limit: two accepts fill the FIFO, same-cycle pop keeps stall
    r_req = 2'b01; r_s_gnt = 1'b1; #1;
    chk("rr_full_gnt_a", r_gnt, 2'b01);
    tick();
    chk("rr_full_gnt_b", r_gnt, 2'b01);
    tick();
    chk("rr_full_sreq", r_s_req, 0);
    chk("rr_full_gnt", r_gnt, 2'b00);
    chk("rr_full_out", r_out, 2);
    chk("rr_full_saddr_zero", r_s_addr, 0);
    r_s_rvalid = 1'b1; #1;
    chk("rr_full_pop_stall", r_s_req, 0);
    chk("rr_full_pop_rv", r_rvalid, 2'b01);
    tick();
    r_s_rvalid = 1'b0; #1;
    chk("rr_full_out_after_pop", r_out, 1);
    chk("rr_full_sreq_reopen", r_s_req, 1);
    chk("rr_full_gnt_reopen", r_gnt, 2'b01);
    tick();
    r_s_gnt = 1'b0; r_req = 2'b11; #1;
    chk("rr_full_out_two", r_out, 2);
    chk("rr_full_sreq_two", r_s_req, 0);

    // Reset with transfers outstanding; pointer returns to master 0
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rr_rst_mid_out", r_out, 0);
    chk("rr_rst_mid_err", r_err, 0);
    r_s_gnt = 1'b1; #1;
    chk("rr_rst_mid_ptr", r_gnt, 2'b01);
    r_s_gnt = 1'b0; r_req = 2'b00; r_s_rvalid = 1'b1; #1;
    chk("rr_stray_rv", r_rvalid, 2'b00);
    tick();
    r_s_rvalid = 1'b0; #1;
    chk("rr_stray_err", r_err, 1);
    chk("rr_stray_out", r_out, 0);
    tick();
    chk("rr_stray_err_sticky", r_err, 1);

    // Fixed priority: master 3 starved, master 1 always wins
    f_req = 4'b1110; f_s_gnt = 1'b1; #1;
    chk("fx_prio_gnt0", f_gnt, 4'b0010);
    chk("fx_prio_addr", f_s_addr, 32'h1000_0010);
    chk("fx_prio_be", f_s_be, 4'h2);
    chk("fx_prio_we", f_s_we, 1);
    chk("fx_prio_wdata", f_s_wdata, 32'hBBBB_BBBB);
    tick();
    chk("fx_prio_gnt1", f_gnt, 4'b0010);
    tick();
    chk("fx_full_sreq", f_s_req, 0);
    chk("fx_full_gnt", f_gnt, 4'b0000);
    chk("fx_full_out", f_out, 2);
    f_s_rvalid = 1'b1; #1;
    chk("fx_full_pop_stall", f_s_req, 0);
    chk("fx_full_rv", f_rvalid, 4'b0010);
    tick();
    chk("fx_pushpop_gnt", f_gnt, 4'b0010);
    chk("fx_pushpop_rv", f_rvalid, 4'b0010);
    tick();
    chk("fx_pushpop_out", f_out, 1);
    f_req = 4'b0000; f_s_gnt = 1'b0; #1;
    chk("fx_drain_rv", f_rvalid, 4'b0010);
    tick();
    f_s_rvalid = 1'b0; #1;
    chk("fx_drain_out", f_out, 0);
    chk("fx_drain_err", f_err, 0);

    // Address-phase lock: master 1 stalled, higher-priority master 0 waits
    f_req = 4'b0010; #1;
    chk("fx_lock_sreq", f_s_req, 1);
    chk("fx_lock_gnt_stall", f_gnt, 4'b0000);
    tick();
    f_req = 4'b0011; #1;
    chk("fx_lock_hold_addr_a", f_s_addr, 32'h1000_0010);
    tick();
    chk("fx_lock_hold_addr_b", f_s_addr, 32'h1000_0010);
    chk("fx_lock_gnt_b", f_gnt, 4'b0000);
    tick();
    f_s_gnt = 1'b1; #1;
    chk("fx_lock_gnt_m1", f_gnt, 4'b0010);
    tick();
    chk("fx_lock_next_m0", f_gnt, 4'b0001);
    chk("fx_lock_addr_m0", f_s_addr, 32'h0000_0000);
    tick();
    f_req = 4'b0000; f_s_gnt = 1'b0; f_s_rvalid = 1'b1; #1;
    chk("fx_lock_rv_m1", f_rvalid, 4'b0010);
    tick();
    chk("fx_lock_rv_m0", f_rvalid, 4'b0001);
    tick();
    f_s_rvalid = 1'b0; #1;
    chk("fx_lock_out_drained", f_out, 0);

    // Locked master withdrawing its request releases the lock
    f_req = 4'b0100; #1;
    tick();
    f_req = 4'b0001; #1;
    chk("fx_lock_drop_addr", f_s_addr, 32'h0000_0000);
    f_req = 4'b0000; #1;

    // Second reset clears the sticky error flag
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rr_err_cleared", r_err, 0);
    chk("fx_err_clean", f_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
